// File: rtl/tick_scheduler_pkg.sv
// ============================================================================
// Module   : tick_scheduler_pkg
// Contents : scheduler state encoding and the default divide-count width.
// Revision : 1.0
// ============================================================================
`default_nettype none

package tick_scheduler_pkg;

    localparam int DEFAULT_CNT_W = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_e;

endpackage

`default_nettype wire

// File: rtl/tick_channel.sv
// ============================================================================
// Module   : tick_channel
// Contents : one divide-by-(D+1) tick channel: divide register, enable,
//            counter, registered tick and, with TICK_SCHEDULER_CLKOUT_EN,
//            a toggling ch_clk output.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tick_channel
    import tick_scheduler_pkg::*;
#(
    parameter int CNT_W = DEFAULT_CNT_W
) (
    input  logic             in_clk,
    input  logic             reset,
    input  logic             run,
    input  logic             stay_run,
    input  logic             clear,
    input  logic             wr,
    input  logic [CNT_W-1:0] wr_div,
    input  logic             wr_en,
`ifdef TICK_SCHEDULER_CLKOUT_EN
    output logic             ch_clk,
`endif
    output logic             tick
);

    logic [CNT_W-1:0] r_div;
    logic [CNT_W-1:0] r_cnt;
    logic             r_en;
    logic             r_tick;
    logic             w_wrap;
    logic             w_fire;

    // Unsigned >= so a lowered divide still reloads at once.
    assign w_wrap = run && r_en && (r_cnt >= r_div);
    // A wrap on the edge that leaves RUN reloads the counter but emits no pulse.
    assign w_fire = w_wrap && stay_run && !wr;

    always_ff @(posedge in_clk) begin
        if (reset) begin
            r_div  <= '0;
            r_en   <= 1'b0;
            r_cnt  <= '0;
            r_tick <= 1'b0;
        end else begin
            r_tick <= w_fire;
            if (wr) begin
                r_div <= wr_div;
                r_en  <= wr_en;
                r_cnt <= '0;
            end else if (clear || !r_en) begin
                r_cnt <= '0;
            end else if (run) begin
                r_cnt <= w_wrap ? '0 : r_cnt + CNT_W'(1);
            end
        end
    end

    assign tick = r_tick;

`ifdef TICK_SCHEDULER_CLKOUT_EN
    logic r_ch_clk;

    always_ff @(posedge in_clk) begin
        if (reset) begin
            r_ch_clk <= 1'b0;
        end else if (w_fire) begin
            r_ch_clk <= !r_ch_clk;
        end
    end

    assign ch_clk = r_ch_clk;
`endif

endmodule

`default_nettype wire

// File: rtl/tick_scheduler.sv
// ============================================================================
// Module   : tick_scheduler
// Contents : IDLE/RUN/PAUSE scheduler driving NUM_CH programmable tick
//            channels; optional ch_clk outputs with TICK_SCHEDULER_CLKOUT_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tick_scheduler
    import tick_scheduler_pkg::*;
#(
    parameter  int NUM_CH = 4,
    parameter  int CNT_W  = DEFAULT_CNT_W,
    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              in_clk,
    input  logic              reset,
    input  logic              start,
    input  logic              stop,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_div,
    input  logic              cfg_en,
`ifdef TICK_SCHEDULER_CLKOUT_EN
    output logic [NUM_CH-1:0] ch_clk,
`endif
    output logic [NUM_CH-1:0] tick,
    output state_e            state,
    output logic              busy
);

    state_e r_state;
    state_e w_next;
    logic   r_ready;
    logic   w_accept;
    logic   w_run;
    logic   w_stay_run;
    logic   w_clear;

    // stop takes priority over start in every state.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (stop) w_next = IDLE;  else if (start) w_next = RUN;
            RUN:     if (stop) w_next = PAUSE;
            PAUSE:   if (stop) w_next = IDLE;  else if (start) w_next = RUN;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge in_clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_ready <= 1'b1;
        end else begin
            r_state <= w_next;
            r_ready <= !w_accept;
        end
    end

    assign w_accept   = cfg_valid && r_ready;
    assign w_run      = (r_state == RUN);
    assign w_stay_run = (w_next == RUN);
    assign w_clear    = (w_next == IDLE);

    assign cfg_ready = r_ready;
    assign state     = r_state;
    assign busy      = w_run;

    // Out-of-range cfg_ch matches no channel, so the write is consumed silently.
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic w_wr;
        assign w_wr = w_accept && (cfg_ch == CH_W'(i));

        tick_channel #(
            .CNT_W (CNT_W)
        ) u_ch (
            .in_clk   (in_clk),
            .reset    (reset),
            .run      (w_run),
            .stay_run (w_stay_run),
            .clear    (w_clear),
            .wr       (w_wr),
            .wr_div   (cfg_div),
            .wr_en    (cfg_en),
`ifdef TICK_SCHEDULER_CLKOUT_EN
            .ch_clk   (ch_clk[i]),
`endif
            .tick     (tick[i])
        );
    end

endmodule

`default_nettype wire

// File: tb/tb_tick_scheduler.sv
// ============================================================================
// Module   : tb_tick_scheduler
// Contents : directed and random stimulus against a countdown reference model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_tick_scheduler;

    localparam int NUM_CH = 3;
    localparam int CNT_W  = 16;

    logic              in_clk = 1'b0;
    logic              reset;
    logic              start;
    logic              stop;
    logic              cfg_valid;
    logic              cfg_ready;
    logic [1:0]        cfg_ch;
    logic [CNT_W-1:0]  cfg_div;
    logic              cfg_en;
    logic [NUM_CH-1:0] tick;
    logic              busy;
    tick_scheduler_pkg::state_e state;
`ifdef TICK_SCHEDULER_CLKOUT_EN
    logic [NUM_CH-1:0] ch_clk;
`endif

    tick_scheduler #(
        .NUM_CH (NUM_CH),
        .CNT_W  (CNT_W)
    ) dut (
        .in_clk    (in_clk),
        .reset     (reset),
        .start     (start),
        .stop      (stop),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_ch    (cfg_ch),
        .cfg_div   (cfg_div),
        .cfg_en    (cfg_en),
`ifdef TICK_SCHEDULER_CLKOUT_EN
        .ch_clk    (ch_clk),
`endif
        .tick      (tick),
        .state     (state),
        .busy      (busy)
    );

    always #5 in_clk = ~in_clk;

    int errors = 0;
    int checks = 0;

    // Reference model: state as 0/1/2, and per channel the number of RUN
    // cycles still to go before the next tick.
    int                m_state;
    bit                m_ready;
    int                m_rem [NUM_CH];
    int                m_div [NUM_CH];
    bit                m_en  [NUM_CH];
    logic [NUM_CH-1:0] m_tick;
    logic [NUM_CH-1:0] m_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        int nxt;
        bit acc;
        if (reset) begin
            m_state = 0;
            m_ready = 1'b1;
            m_tick  = '0;
            m_clk   = '0;
            for (int i = 0; i < NUM_CH; i++) begin
                m_div[i] = 0;
                m_en[i]  = 1'b0;
                m_rem[i] = 1;
            end
        end else begin
            acc = cfg_valid && m_ready;
            case (m_state)
                0:       nxt = stop ? 0 : (start ? 1 : 0);
                1:       nxt = stop ? 2 : 1;
                default: nxt = stop ? 0 : (start ? 1 : 2);
            endcase
            m_tick = '0;
            for (int i = 0; i < NUM_CH; i++) begin
                if (acc && int'(cfg_ch) == i) begin
                    m_div[i] = int'(cfg_div);
                    m_en[i]  = cfg_en;
                    m_rem[i] = int'(cfg_div) + 1;
                end else if (nxt == 0 || !m_en[i]) begin
                    m_rem[i] = m_div[i] + 1;
                end else if (m_state == 1) begin
                    m_rem[i]--;
                    if (m_rem[i] == 0) begin
                        m_rem[i]  = m_div[i] + 1;
                        m_tick[i] = (nxt == 1);
                    end
                end
            end
            m_clk   = m_clk ^ m_tick;
            m_state = nxt;
            m_ready = !acc;
        end
        @(posedge in_clk);
        #1;
        check("state", 32'(state), 32'(m_state));
        check("busy", 32'(busy), 32'(m_state == 1));
        check("cfg_ready", 32'(cfg_ready), 32'(m_ready));
        check("tick", 32'(tick), 32'(m_tick));
`ifdef TICK_SCHEDULER_CLKOUT_EN
        check("ch_clk", 32'(ch_clk), 32'(m_clk));
`endif
    endtask

    task automatic write(input int ch, input int div, input bit en);
        cfg_valid = 1'b1;
        cfg_ch    = 2'(ch);
        cfg_div   = CNT_W'(div);
        cfg_en    = en;
        step();
        cfg_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; stop = 1'b0;
        cfg_valid = 1'b0; cfg_ch = '0; cfg_div = '0; cfg_en = 1'b0;

        // Reset values
        step();
        step();
        check("rst_state", 32'(state), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ready", 32'(cfg_ready), 32'd1);
        check("rst_tick", 32'(tick), 32'd0);
        reset = 1'b0;

        // ch0 D=3: ticks at 4, 8, 12 after RUN entry
        write(0, 3, 1'b1);
        check("ready_after_wr", 32'(cfg_ready), 32'd0);
        step();
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            step();
            check("d3_tick", 32'(tick), (k % 4 == 0) ? 32'd1 : 32'd0);
        end

        // ch1 D=0 ticks every cycle; ch2 disabled stays quiet
        write(1, 0, 1'b1);
        check("d0_first", 32'(tick[1]), 32'd0);
        for (int k = 1; k <= 8; k++) begin
            step();
            check("d0_tick1", 32'(tick[1]), 32'd1);
            check("dis_tick2", 32'(tick[2]), 32'd0);
        end

        // Back-to-back cfg_valid: accepted on cycles 0 and 2 only
        cfg_valid = 1'b1; cfg_ch = 2'd2; cfg_en = 1'b1;
        check("b2b_ready0", 32'(cfg_ready), 32'd1);
        cfg_div = CNT_W'(2);
        step();
        check("b2b_ready1", 32'(cfg_ready), 32'd0);
        cfg_div = CNT_W'(0);
        step();
        check("b2b_ready2", 32'(cfg_ready), 32'd1);
        cfg_div = CNT_W'(4);
        step();
        cfg_valid = 1'b0;
        for (int k = 0; k < 12; k++) step();

        // Pause at counter 5 with D=9, resume: tick 4 cycles later
        do_reset();
        write(0, 9, 1'b1);
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k < 5; k++) step();
        stop = 1'b1;
        step();
        stop = 1'b0;
        for (int k = 0; k < 20; k++) begin
            step();
            check("pause_tick", 32'(tick), 32'd0);
        end
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            step();
            check("resume_tick", 32'(tick[0]), (k == 4) ? 32'd1 : 32'd0);
        end

        // start+stop together -> PAUSE, stop -> IDLE, restart from zero
        start = 1'b1; stop = 1'b1;
        step();
        check("both_pause", 32'(state), 32'd2);
        start = 1'b0;
        step();
        check("stop_idle", 32'(state), 32'd0);
        stop = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            step();
            check("idle_cleared", 32'(tick[0]), (k == 10) ? 32'd1 : 32'd0);
        end

        // Reset mid-RUN overrides start/stop/cfg_valid
        write(1, 0, 1'b1);
        reset = 1'b1; start = 1'b1; cfg_valid = 1'b1;
        step();
        check("mid_rst_state", 32'(state), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_ready", 32'(cfg_ready), 32'd1);
        check("mid_rst_tick", 32'(tick), 32'd0);
        reset = 1'b0; start = 1'b0; cfg_valid = 1'b0;

`ifdef TICK_SCHEDULER_CLKOUT_EN
        write(0, 1, 1'b1);
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            step();
            check("clkout", 32'(ch_clk[0]), (((k / 2) % 2) == 1) ? 32'd1 : 32'd0);
        end
        do_reset();
`endif

        // Random traffic, including out-of-range channel writes
        for (int k = 0; k < 400; k++) begin
            start     = ($urandom_range(0, 3) == 0);
            stop      = ($urandom_range(0, 9) == 0);
            cfg_valid = ($urandom_range(0, 5) == 0);
            cfg_ch    = 2'($urandom_range(0, 3));
            cfg_div   = CNT_W'($urandom_range(0, 7));
            cfg_en    = ($urandom_range(0, 3) != 0);
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/tick_scheduler.md
TICK_SCHEDULER -- requirements
Module: tick_scheduler

Interface
REQ-001 Parameter NUM_CH, default 4, number of independent tick channels (1..16).
REQ-002 Parameter CNT_W, default 32, width of each channel's divide count.
REQ-003 in_clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  level, sampled each edge; requests RUN.
REQ-006 stop  input  1  level, sampled each edge; requests PAUSE, or IDLE when already paused.
REQ-007 cfg_valid  input  1  configuration write request.
REQ-008 cfg_ready  output  1  configuration write may be accepted this cycle.
REQ-009 cfg_ch  input  $clog2(NUM_CH) (min 1)  target channel of the write.
REQ-010 cfg_div  input  CNT_W  divide count D; channel period is D+1 in_clk cycles.
REQ-011 cfg_en  input  1  channel enable written with D.
REQ-012 tick  output  NUM_CH  per-channel one-cycle pulse, registered.
REQ-013 state  output  2  current scheduler state encoding (package enum).
REQ-014 busy  output  1  high when state is RUN.

Function
REQ-015 The FSM SHALL have states IDLE, RUN and PAUSE.
REQ-016 IDLE->RUN on start; RUN->PAUSE on stop; PAUSE->RUN on start; PAUSE->IDLE on stop.
REQ-017 start and stop asserted in the same cycle: stop SHALL win.
REQ-018 In RUN, each enabled channel counter SHALL increment by 1 per cycle.
REQ-019 When a channel counter is >= its D, it SHALL reload 0 on the next edge and set that channel's tick bit for exactly one cycle.
REQ-020 First tick SHALL be high D+1 cycles after the edge that entered RUN, then every D+1 cycles; D=0 gives tick high every cycle.
REQ-021 In PAUSE, counters SHALL hold their values and tick SHALL be 0; resume continues from held values.
REQ-022 Entering IDLE SHALL clear all counters to 0; tick SHALL be 0 in IDLE.
REQ-023 Disabled channels SHALL hold counter at 0 and never tick.
REQ-024 A write completes when cfg_valid and cfg_ready are both high at an edge; it updates D and enable for cfg_ch and clears that channel's counter to 0.
REQ-025 cfg_ready SHALL be 1 except in the cycle immediately after an accepted write, when it SHALL be 0.
REQ-026 A write to a channel in the same edge its counter reaches D: write SHALL win; no tick is produced for that channel.
REQ-027 cfg_ch >= NUM_CH SHALL be accepted and ignored.
REQ-028 Counter comparison is unsigned; counters SHALL never exceed D after a write lowers D (>= reloads immediately).

Reset
REQ-029 On reset: state=IDLE, all counters 0, all D=0, all enables 0, tick=0, busy=0, cfg_ready=1.
REQ-030 Reset mid-RUN SHALL take effect at the next edge, overriding start, stop and cfg_valid.

Configuration
REQ-031 With TICK_SCHEDULER_CLKOUT_EN defined: extra output ch_clk[NUM_CH], each bit toggling on every tick of its channel (50% duty, period 2(D+1)), reset 0, held in PAUSE/IDLE.
REQ-032 Without TICK_SCHEDULER_CLKOUT_EN: port ch_clk and its logic SHALL not exist; all other behaviour identical.

Structure
REQ-033 Package tick_scheduler_pkg SHALL hold the state enum (IDLE=0, RUN=1, PAUSE=2) and default CNT_W constant.
REQ-034 One sub-module tick_channel SHALL implement one counter/compare/tick (and ch_clk when enabled), instantiated NUM_CH times; FSM and config decode in top.

Verification
REQ-035 Reset, write ch0 D=3 en=1, start -> ch0 tick high at cycles 4,8,12 after RUN entry; others 0.
REQ-036 ch1 D=0 en=1 in RUN -> tick[1] high every cycle; ch2 disabled -> tick[2] always 0.
REQ-037 RUN with ch0 D=9, stop at counter=5, hold 20 cycles, start -> next tick 4 cycles after resume; no ticks while paused.
REQ-038 Back-to-back cfg_valid for 3 cycles -> writes accepted cycles 0 and 2 only; cfg_ready 1,0,1.
REQ-039 start and stop together from RUN -> PAUSE; stop again -> IDLE, counters 0; assert reset mid-RUN -> all outputs at reset values next cycle.
REQ-040 With TICK_SCHEDULER_CLKOUT_EN, D=1 -> ch_clk period 4 cycles, 50% duty.
